// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver.
// A prescaler paces the digit scan. Captured values wait in a pending register and are
// committed to the display only at the start of a frame (digit index wraps 7 -> 0), so
// a frame never mixes two values.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        value_load,
  input  logic [7:0]  dp_in,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN,
  output logic        pending
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            lit_q, lit_d;
  logic [31:0]     disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [7:0]      disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [7:0]      an_q, an_d;
  logic            tick, wrap;
  logic [3:0]      nib;

  // Hex to {CA..CG}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == 3'd7);

  // Prescaler, digit index and value capture/commit.
  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 3'd1 : idx_q;
    lit_d      = lit_q | tick;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    if (wrap) begin
      if (value_load) begin
        // A load on the frame boundary bypasses the pending stage.
        disp_val_d = value_in;
        disp_dp_d  = dp_in;
        pend_val_d = value_in;
        pend_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pending_d = 1'b0;
    end else if (value_load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pending_d  = 1'b1;
    end
  end

  // Output decode for the current digit; registered on the next edge.
  always_comb begin
    nib  = disp_val_q[{idx_q, 2'b00} +: 4];
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit_q) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = seg_decode(nib);
      dp_d  = ~disp_dp_q[idx_q];
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin : g_blank
      logic [2:0] msd;
      msd = 3'd0;
      for (int k = 1; k < 8; k++) begin
        if (disp_val_q[4*k +: 4] != 4'h0) msd = 3'(k);
      end
      if ((idx_q > msd) && !disp_dp_q[idx_q]) begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
    end
`endif
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= 3'd7;
      lit_q      <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lit_q      <= lit_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP      = dp_q;
  assign AN      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV = 4. The reference model works from edge
// counts: which frame boundaries have passed and which loads preceded them.
module tb_seg7_scan_driver;

  localparam int D = 4;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [31:0] value_in;
  logic        value_load;
  logic [7:0]  dp_in;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, pending;
  logic [7:0]  AN;

  int checks = 0;
  int errors = 0;
  int e = 0;  // rising edges since reset release

  int          ld_edge[$];
  logic [31:0] ld_val[$];
  logic [7:0]  ld_dp[$];

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg7_scan_driver #(.REFRESH_DIV(D)) dut (
    .clk_100(clk_100), .reset(reset), .value_in(value_in), .value_load(value_load),
    .dp_in(dp_in), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN), .pending(pending)
  );

  always #5 clk_100 = ~clk_100;

  // Edge of the most recent frame start (index becomes 0) at or before edge x, else -1.
  function automatic int last_wrap(input int x);
    int m;
    if (x < D) return -1;
    m = (x / D - 1) / 8;
    return D * (8 * m + 1);
  endfunction

  function automatic void disp_at(input int x, output logic [31:0] v, output logic [7:0] d);
    int w;
    w = last_wrap(x);
    v = '0;
    d = '0;
    foreach (ld_edge[i]) if (ld_edge[i] <= w) begin v = ld_val[i]; d = ld_dp[i]; end
  endfunction

  function automatic logic pend_at(input int x);
    int w;
    w = last_wrap(x);
    foreach (ld_edge[i]) if (ld_edge[i] > w && ld_edge[i] <= x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_pend;
    logic [31:0] v;
    logic [7:0]  d;
    int          t, k;
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    exp_pend = pend_at(e);
    t = (e - 1) / D;
    if (e >= 1 && t >= 1) begin
      k = (t - 1) % 8;
      disp_at(e - 1, v, d);
      exp_an  = ~(8'd1 << k);
      exp_seg = seg_tab[(v >> (4 * k)) & 32'hF];
      exp_dp  = ~d[k];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      begin
        int msd;
        msd = 0;
        for (int j = 1; j < 8; j++) if (((v >> (4 * j)) & 32'hF) != 0) msd = j;
        if (k > msd && !d[k]) begin exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; end
      end
`endif
    end
    checks++;
    assert (AN === exp_an) else begin
      errors++; $error("FAIL an e=%0d: got %h exp %h", e, AN, exp_an);
    end
    checks++;
    assert ({CA, CB, CC, CD, CE, CF, CG} === exp_seg) else begin
      errors++; $error("FAIL seg e=%0d: got %b exp %b", e, {CA, CB, CC, CD, CE, CF, CG}, exp_seg);
    end
    checks++;
    assert (DP === exp_dp) else begin
      errors++; $error("FAIL dp e=%0d: got %b exp %b", e, DP, exp_dp);
    end
    checks++;
    assert (pending === exp_pend) else begin
      errors++; $error("FAIL pending e=%0d: got %b exp %b", e, pending, exp_pend);
    end
  endtask

  // One clock cycle; inputs applied before the edge, outputs checked on the falling edge.
  task automatic cyc(input logic ld, input logic [31:0] v, input logic [7:0] d);
    value_load = ld; value_in = v; dp_in = d;
    @(posedge clk_100);
    e++;
    if (ld) begin ld_edge.push_back(e); ld_val.push_back(v); ld_dp.push_back(d); end
    @(negedge clk_100);
    value_load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 8'h0);
  endtask

  task automatic check_off(input string tag);
    checks++;
    assert (AN === 8'hFF && {CA, CB, CC, CD, CE, CF, CG, DP} === 8'hFF && pending === 1'b0)
    else begin
      errors++;
      $error("FAIL %s: got an=%h seg_dp=%b pending=%b exp an=ff seg_dp=11111111 pending=0",
             tag, AN, {CA, CB, CC, CD, CE, CF, CG, DP}, pending);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; value_load = 1'b0; value_in = '0; dp_in = '0;
    @(negedge clk_100);
    @(negedge clk_100);
    check_off("reset_state");
    reset = 1'b0;
    e = 0;
    check_all();

    // Free run: digit 0 shows "0" after the first tick, then AN walks.
    idle(40);

    // Load during mid-frame, held pending until the next frame start.
    cyc(1'b1, 32'h89ABCDEF, 8'h01);
    idle(40);

    // Two loads before the boundary: last one wins.
    cyc(1'b1, 32'h11111111, 8'h00);
    idle(3);
    cyc(1'b1, 32'h22222222, 8'h00);
    idle(40);

    // Load exactly on a frame-start edge commits directly.
    n = 0;
    while (!((e + 1) % D == 0 && ((e + 1) / D) % 8 == 1) && n < 64) begin
      idle(1);
      n++;
    end
    checks++;
    assert (n < 64) else begin
      errors++; $error("FAIL wrap_search: got %0d cycles exp <64", n);
    end
    cyc(1'b1, 32'h00000005, 8'h00);
    idle(36);

    cyc(1'b1, 32'h00000A30, 8'h04);
    idle(40);

    // Randomized loads.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) cyc(1'b1, $urandom, 8'($urandom));
      else idle(1);
    end

    // Reset while a value is pending; it must never appear.
    idle(2);
    cyc(1'b1, 32'h76543210, 8'hFF);
    idle(2);
    #2 reset = 1'b1;
    #1 check_off("mid_reset");
    ld_edge.delete(); ld_val.delete(); ld_dp.delete();
    @(negedge clk_100);
    check_off("held_reset");
    reset = 1'b0;
    e = 0;
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
